// File: rtl/axis_rr_pkt_mux_pkg.sv
// ---------------------------------------------------------------------------
// axis_mux_pkg
// Shared definitions for the round-robin AXI-Stream packet multiplexer.
//   state_t : two-state arbitration FSM encoding (ST_IDLE / ST_LOCK)
//   MAX_CH  : largest number of slave channels the mux is built for
// ---------------------------------------------------------------------------
package axis_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int MAX_CH = 16;

endpackage

// File: rtl/axis_rr_pkt_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational cyclic-priority search. The channel just after i_ptr has the
// highest priority, i_ptr itself the lowest (the search wraps NUM_CH-1 -> 0).
// Ports:
//   i_req    [NUM_CH] request vector (one bit per channel)
//   i_ptr    [CH_W]   last granted channel
//   o_grant  [CH_W]   winning channel index (0 when nothing requests)
//   o_anyReq          at least one request bit is set
// ---------------------------------------------------------------------------
module rr_arbiter
    import axis_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [CH_W-1:0]   o_grant,
    output logic              o_anyReq
);

    localparam int ARB_N = (NUM_CH < MAX_CH) ? NUM_CH : MAX_CH;

    int w_dist;
    int w_bestDist;

    // Each requester gets a distance from the pointer: 0 for the channel right
    // after it, NUM_CH-1 for the pointer itself. The smallest distance wins,
    // which is exactly the cyclic search order without a variable rotate.
    always_comb begin
        o_grant    = '0;
        o_anyReq   = 1'b0;
        w_dist     = 0;
        w_bestDist = 0;
        for (int c = 0; c < ARB_N; c++) begin
            if (i_req[c]) begin
                w_dist = (c + NUM_CH - 1 - int'(i_ptr)) % NUM_CH;
                if (!o_anyReq || (w_dist < w_bestDist)) begin
                    w_bestDist = w_dist;
                    o_grant    = CH_W'(c);
                    o_anyReq   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_rr_pkt_mux.sv
// ---------------------------------------------------------------------------
// axis_rr_pkt_mux
// N-input AXI-Stream packet multiplexer with round-robin arbitration. One
// channel is granted at a time and keeps the grant until its s_last beat is
// accepted; every packet boundary costs one IDLE arbitration cycle. The master
// side is a single registered output slice that can load and drain in the
// same cycle, giving one beat per cycle inside a packet.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   s_data/valid/last   packed per-channel slave inputs (channel i data at
//                       bits [i*DATA_W +: DATA_W])
//   s_ready             per-channel ready, only ever set for the granted one
//   m_data/valid/last   registered master outputs
//   m_ready             master backpressure
//   m_id                source channel of the current master beat
// Build option: define AXIS_MUX_ID_EN to add the m_id port and its register.
// ---------------------------------------------------------------------------
module axis_rr_pkt_mux
    import axis_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_valid,
    input  logic [NUM_CH-1:0]        s_last,
    output logic [NUM_CH-1:0]        s_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready
`ifdef AXIS_MUX_ID_EN
    ,
    output logic [CH_W-1:0]          m_id
`endif
);

    state_t              r_state;
    state_t              w_nextState;
    logic [CH_W-1:0]     r_grant;
    logic [CH_W-1:0]     r_rrPtr;
    logic [CH_W-1:0]     w_arbGrant;
    logic                w_anyReq;
    logic                w_loadOk;
    logic                w_accept;
    logic                w_selValid;
    logic                w_selLast;
    logic [DATA_W-1:0]   w_selData;
    logic [DATA_W-1:0]   r_mData;
    logic                r_mValid;
    logic                r_mLast;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req    (s_valid),
        .i_ptr    (r_rrPtr),
        .o_grant  (w_arbGrant),
        .o_anyReq (w_anyReq)
    );

    // The output slot can take a new beat when it is empty or being drained
    // this cycle; this keeps s_ready independent of s_valid.
    assign w_loadOk = !r_mValid || m_ready;

    // Pick the granted channel's slave signals with constant indices so the
    // mux stays a plain compare-and-select per channel.
    always_comb begin
        w_selValid = 1'b0;
        w_selLast  = 1'b0;
        w_selData  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_grant == CH_W'(c)) begin
                w_selValid = s_valid[c];
                w_selLast  = s_last[c];
                w_selData  = s_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and slave-ready decode. IDLE spends one cycle arbitrating;
    // LOCK forwards beats from the granted channel until its last beat.
    always_comb begin
        w_nextState = r_state;
        s_ready     = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ST_LOCK;
                end
            end
            ST_LOCK: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (r_grant == CH_W'(c)) begin
                        s_ready[c] = w_loadOk;
                    end
                end
                w_accept = w_selValid && w_loadOk;
                if (w_accept && w_selLast) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // State register plus grant/pointer capture. The pointer starts at the
    // last channel so channel 0 wins the first arbitration after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_rrPtr <= CH_W'(NUM_CH - 1);
        end else begin
            r_state <= w_nextState;
            if ((r_state == ST_IDLE) && w_anyReq) begin
                r_grant <= w_arbGrant;
                r_rrPtr <= w_arbGrant;
            end
        end
    end

    // Output slice: data/last only change on a load, so they hold under
    // backpressure; valid drops only when drained with nothing new loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mData  <= '0;
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end else if (w_accept) begin
            r_mData  <= w_selData;
            r_mValid <= 1'b1;
            r_mLast  <= w_selLast;
        end else if (r_mValid && m_ready) begin
            r_mValid <= 1'b0;
        end
    end

    assign m_data  = r_mData;
    assign m_valid = r_mValid;
    assign m_last  = r_mLast;

`ifdef AXIS_MUX_ID_EN
    logic [CH_W-1:0] r_mId;

    // Source index travels with the beat it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mId <= '0;
        end else if (w_accept) begin
            r_mId <= r_grant;
        end
    end

    assign m_id = r_mId;
`endif

endmodule
